// File: rtl/linebuf_pkg.sv
// -----------------------------------------------------------------------------
// linebuf_pkg
//   Shared constants and helpers for the linebuf_taps line buffer.
//   LEN_MIN   : shortest legal line length. Below this, the read-ahead address
//               could match the write address.
//   clamp_len : forces a requested line length into [LEN_MIN, 2**addr_w].
// -----------------------------------------------------------------------------
package linebuf_pkg;

    localparam int unsigned LEN_MIN = 2;

    function automatic logic [31:0] clamp_len(input logic [31:0] len,
                                              input int unsigned addr_w);
        logic [31:0] len_max;
        len_max = 32'd1 << addr_w;
        if (len < LEN_MIN) begin
            return LEN_MIN;
        end else if (len > len_max) begin
            return len_max;
        end
        return len;
    endfunction

endpackage

// File: rtl/linebuf_ram.sv
// -----------------------------------------------------------------------------
// linebuf_ram
//   Simple dual-port RAM. It has one write port and one registered read port.
//   When the read and write addresses collide, the read returns the old data.
//   The contents are never reset, so the RAM can map onto block RAM.
// Ports
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_raddr  in   read address. The data appears on o_rdata after one clock.
//   o_rdata  out  registered read data
// -----------------------------------------------------------------------------
module linebuf_ram #(
    parameter int unsigned WIDTH_ = 8,
    parameter int unsigned ADDR_  = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_-1:0]  i_waddr,
    input  logic [WIDTH_-1:0] i_wdata,
    input  logic [ADDR_-1:0]  i_raddr,
    output logic [WIDTH_-1:0] o_rdata
);

    logic [WIDTH_-1:0] r_mem [2**ADDR_];
    logic [WIDTH_-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/linebuf_taps.sv
// -----------------------------------------------------------------------------
// linebuf_taps
//   Multi-channel, multi-tap line buffer. Each RAM word holds every tap for one
//   column, with tap 0 in the LSBs. Each push rewrites the word one tap deeper
//   and puts the new sample in tap 0. taps[k] lags din by (k+1)*len pushes.
//   The compile macro LINEBUF_MASK_EN forces taps[k] to 0 while tap_vld[k]=0.
//   Without the macro, taps carries raw RAM data.
// Ports
//   clk        in   clock
//   aclr_n     in   asynchronous active-low reset
//   flush      in   synchronous clear of pointer and fill state. Latches len.
//   len        in   line length. Sampled on the first clk after reset and on flush.
//   in_valid   in   push din this cycle
//   din        in   input sample, CH_ channels
//   out_valid  out  one pulse per accepted push
//   taps       out  TAPS_ delayed samples
//   tap_vld    out  per-tap valid flag
// -----------------------------------------------------------------------------
module linebuf_taps
    import linebuf_pkg::*;
#(
    parameter int unsigned DATA_ = 8,
    parameter int unsigned CH_   = 1,
    parameter int unsigned TAPS_ = 3,
    parameter int unsigned ADDR_ = 8
) (
    input  logic                                 clk,
    input  logic                                 aclr_n,
    input  logic                                 flush,
    input  logic [ADDR_:0]                       len,
    input  logic                                 in_valid,
    input  logic [CH_-1:0][DATA_-1:0]            din,
    output logic                                 out_valid,
    output logic [TAPS_-1:0][CH_-1:0][DATA_-1:0] taps,
    output logic [TAPS_-1:0]                     tap_vld
);

    localparam int unsigned WORD_W  = TAPS_ * CH_ * DATA_;
    localparam int unsigned LINES_W = $clog2(TAPS_ + 1);

    logic [ADDR_-1:0]                       r_wr_ptr;
    logic [ADDR_:0]                         r_len_q;
    logic                                   r_len_pend;
    logic [LINES_W-1:0]                     r_lines;
    logic                                   r_out_valid;
    logic [TAPS_-1:0][CH_-1:0][DATA_-1:0]   r_taps;
    logic [TAPS_-1:0]                       r_tap_vld;

    logic                                   w_push;
    logic                                   w_wrap;
    logic [ADDR_:0]                         w_len_clamp;
    logic [ADDR_:0]                         w_len_eff;
    logic [ADDR_-1:0]                       w_ptr_next;
    logic [ADDR_-1:0]                       w_rd_addr;
    logic [TAPS_-1:0][CH_-1:0][DATA_-1:0]   w_q;
    logic [TAPS_-1:0][CH_-1:0][DATA_-1:0]   w_wdata;
    logic [TAPS_-1:0]                       w_vld_next;

    assign w_push      = in_valid & ~flush;
    assign w_len_clamp = (ADDR_+1)'(clamp_len(32'(len), ADDR_));
    // The first clock after reset release already uses the freshly sampled length.
    assign w_len_eff   = r_len_pend ? w_len_clamp : r_len_q;
    assign w_wrap      = ({1'b0, r_wr_ptr} == (w_len_eff - (ADDR_+1)'(1)));
    assign w_ptr_next  = w_wrap ? '0 : r_wr_ptr + ADDR_'(1);

    // Read ahead so that q holds mem[wr_ptr] whenever the next push arrives.
    // A flush resets the pointer, so the RAM reads address 0 in that cycle.
    assign w_rd_addr = flush  ? '0 :
                       w_push ? w_ptr_next : r_wr_ptr;

    always_comb begin
        w_wdata    = '0;
        w_wdata[0] = din;
        for (int k = 1; k < TAPS_; k++) begin
            w_wdata[k] = w_q[k-1];
        end
    end

    // The fill level before this push decides which taps hold real data.
    always_comb begin
        w_vld_next = '0;
        for (int k = 0; k < TAPS_; k++) begin
            w_vld_next[k] = (int'(r_lines) > k);
        end
    end

    linebuf_ram #(
        .WIDTH_ (WORD_W),
        .ADDR_  (ADDR_)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (w_rd_addr),
        .o_rdata (w_q)
    );

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_wr_ptr    <= '0;
            r_len_q     <= (ADDR_+1)'(LEN_MIN);
            r_len_pend  <= 1'b1;
            r_lines     <= '0;
            r_out_valid <= 1'b0;
            r_taps      <= '0;
            r_tap_vld   <= '0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_len_q     <= w_len_clamp;
            r_len_pend  <= 1'b0;
            r_lines     <= '0;
            r_out_valid <= 1'b0;
            r_tap_vld   <= '0;
        end else begin
            if (r_len_pend) begin
                r_len_q    <= w_len_clamp;
                r_len_pend <= 1'b0;
            end
            r_out_valid <= w_push;
            if (w_push) begin
                r_wr_ptr  <= w_ptr_next;
                r_taps    <= w_q;
                r_tap_vld <= w_vld_next;
                if (w_wrap && (32'(r_lines) < TAPS_)) begin
                    r_lines <= r_lines + LINES_W'(1);
                end
            end
        end
    end

    always_comb begin
        taps = r_taps;
`ifdef LINEBUF_MASK_EN
        for (int k = 0; k < TAPS_; k++) begin
            if (!r_tap_vld[k]) begin
                taps[k] = '0;
            end
        end
`endif
    end

    assign out_valid = r_out_valid;
    assign tap_vld   = r_tap_vld;

endmodule
